fifo_drain_ctrl: RTL and testbench
==================================

// Module: fifo_drain_ctrl
// PURPOSE
// Read-side master for the multi-cycle-read FIFO. Issues pops while the FIFO is non-empty,
// tracks pops in flight across the FIFO's fixed read latency, and captures returned words
// on the read_en strobe into a local elastic buffer. The buffer feeds a downstream
// valid/ready stream. Sits between the FIFO and any consumer that may stall.
// PARAMETERS
// DATA_WIDTH    8   width of FIFO data and stream data
// READ_LATENCY  4   cycles from pop issue to read_en/data return; must be >= 1
// BUF_DEPTH     8   local buffer entries; power of 2; must be >= READ_LATENCY+1
// PORTS
// clock          in   1              system clock, all logic on posedge
// reset          in   1              asynchronous, active-low reset
// enable         in   1              1 = drain FIFO; 0 = stop issuing pops
// fifo_empty     in   1              FIFO empty flag
// fifo_pop       out  1              pop request to FIFO, one word per asserted cycle
// fifo_data      in   DATA_WIDTH     FIFO read data, valid when fifo_read_en=1
// fifo_read_en   in   1              FIFO return strobe, READ_LATENCY cycles after pop
// m_valid        out  1              stream word available
// m_ready        in   1              consumer accepts word when m_valid&&m_ready
// m_data         out  DATA_WIDTH     stream data (head of local buffer)
// busy           out  1              1 while state != IDLE
// in_flight      out  $clog2(BUF_DEPTH)+1  pops issued, data not yet returned
// err_unexp      out  1              sticky: read_en seen with in_flight==0
// BEHAVIOUR
// - Reset (async, reset=0): state=IDLE, fifo_pop=0, m_valid=0, m_data=0, busy=0,
//   in_flight=0, err_unexp=0, buffer pointers/count=0. Reset mid-transfer discards in-flight
//   and buffered data; returns arriving after reset release set err_unexp.
// - fifo_pop is combinational: state==RUN && !fifo_empty && (in_flight+buf_count < BUF_DEPTH).
//   Credit check counts the word being popped out this cycle as freed (m_valid&&m_ready).
// - in_flight: +1 on pop, -1 on fifo_read_en, unchanged when both or neither. Never exceeds
//   BUF_DEPTH; never wraps below 0 (read_en at 0 keeps 0, sets err_unexp, data dropped).
// - Capture: fifo_read_en=1 writes fifo_data at buffer wr_ptr, wr_ptr+1 mod BUF_DEPTH.
//   Credit scheme guarantees buffer never overflows; no full-drop path needed.
// - Stream: m_valid = (buf_count!=0); m_data = buffer[rd_ptr]. On m_valid&&m_ready,
//   rd_ptr+1 mod BUF_DEPTH. Capture and pop in same cycle: count unchanged. Capture into
//   empty buffer: m_valid rises the next cycle (1-cycle latency, no bypass).
// - m_data/m_valid stable while m_valid && !m_ready.
// - Throughput: with m_ready=1 and FIFO non-empty, one word per cycle sustained;
//   first m_valid at READ_LATENCY+1 cycles after first pop.
// - FSM: IDLE --enable=1--> RUN; RUN --enable=0--> STOP;
//   STOP --in_flight==0 (after update)--> IDLE; STOP --enable=1--> RUN.
//   Buffered words keep draining to stream in every state.
// - FIFO empty mid-run: pops stall, no state change; resume when fifo_empty=0.
// - busy = (state!=IDLE). err_unexp cleared only by reset.
// TESTING
// 1 Reset: reset=0 during traffic -> all outputs 0 next cycle regardless of clock; after release, m_valid=0, in_flight=0.
// 2 Stream: FIFO holds 0x11..0x1A, enable=1, m_ready=1 -> 10 pops on cycles 1..10, m_data 0x11..0x1A in order, m_valid first high at cycle 6, no gaps.
// 3 Backpressure: m_ready=0 from start, 20 words in FIFO -> exactly 8 pops issued, in_flight peaks 4, buffer fills to 8, no pops until m_ready=1; then order preserved.
// 4 Stop: enable=0 with in_flight=3 -> state STOP, fifo_pop=0, 3 returns captured, busy falls cycle after in_flight hits 0.
// 5 Empty stall: FIFO empties after 2 words, refills 5 cycles later -> fifo_pop gaps while empty, stream resumes, no duplicates/losses.
// 6 Spurious: fifo_read_en=1 with in_flight=0, data 0xAA -> err_unexp=1 sticky, 0xAA not on stream.

Source files
------------

// File: rtl/fifo_drain_ctrl.sv
// Read-side master for a fixed-latency FIFO: issues credit-limited pops, tracks
// pops in flight and buffers returned words for a valid/ready consumer.
module fifo_drain_ctrl #(
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned READ_LATENCY = 4,
    parameter int unsigned BUF_DEPTH    = 8
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         enable,
    input  logic                         fifo_empty,
    output logic                         fifo_pop,
    input  logic [DATA_WIDTH-1:0]        fifo_data,
    input  logic                         fifo_read_en,
    output logic                         m_valid,
    input  logic                         m_ready,
    output logic [DATA_WIDTH-1:0]        m_data,
    output logic                         busy,
    output logic [$clog2(BUF_DEPTH):0]   in_flight,
    output logic                         err_unexp
);

    localparam int unsigned PW = $clog2(BUF_DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned SW = CW + 1;
    localparam bit CFG_OK = (READ_LATENCY >= 1) && (BUF_DEPTH >= READ_LATENCY + 1)
                            && ((1 << PW) == BUF_DEPTH);

    if (!CFG_OK) begin : g_bad_cfg
        $error("fifo_drain_ctrl: BUF_DEPTH must be a power of 2 and >= READ_LATENCY+1");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic [DATA_WIDTH-1:0] mem [BUF_DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [CW-1:0]         buf_count;
    logic [CW-1:0]         in_flight_nxt;
    logic [SW-1:0]         credit_used;
    logic                  pop_out;
    logic                  unexp;
    logic                  capture;

    assign m_valid  = (buf_count != '0);
    assign m_data   = mem[rd_ptr];
    assign busy     = (state != IDLE);
    assign pop_out  = m_valid && m_ready;

    // A return with nothing outstanding is spurious: flag it and drop the data.
    assign unexp    = fifo_read_en && (in_flight == '0);
    assign capture  = fifo_read_en && !unexp;

    // Credits cover both outstanding pops and buffered words; the word leaving now is free.
    assign credit_used   = SW'(in_flight) + SW'(buf_count) - SW'(pop_out);
    assign fifo_pop      = (state == RUN) && !fifo_empty && (credit_used < SW'(BUF_DEPTH));
    assign in_flight_nxt = in_flight + CW'(fifo_pop) - CW'(capture);

    // Next-state logic; STOP leaves once the post-update in-flight count is zero.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (enable) state_nxt = RUN;
            RUN:  if (!enable) state_nxt = STOP;
            STOP: begin
                if (enable)                   state_nxt = RUN;
                else if (in_flight_nxt == '0) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            in_flight <= '0;
            err_unexp <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            buf_count <= '0;
            for (int unsigned i = 0; i < BUF_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            state     <= state_nxt;
            in_flight <= in_flight_nxt;
            buf_count <= buf_count + CW'(capture) - CW'(pop_out);
            if (unexp) begin
                err_unexp <= 1'b1;
            end
            if (capture) begin
                mem[wr_ptr] <= fifo_data;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (pop_out) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
        end
    end

endmodule

// File: tb/tb_fifo_drain_ctrl.sv
// Directed bench for fifo_drain_ctrl with a fixed-latency FIFO model and stream collector.
module tb_fifo_drain_ctrl;

    localparam int unsigned DW  = 8;
    localparam int unsigned LAT = 4;
    localparam int unsigned BD  = 8;

    logic          clock;
    logic          reset;
    logic          enable;
    logic          fifo_empty;
    logic          fifo_pop;
    logic [DW-1:0] fifo_data;
    logic          fifo_read_en;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic          busy;
    logic [3:0]    in_flight;
    logic          err_unexp;

    fifo_drain_ctrl #(
        .DATA_WIDTH  (DW),
        .READ_LATENCY(LAT),
        .BUF_DEPTH   (BD)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .enable      (enable),
        .fifo_empty  (fifo_empty),
        .fifo_pop    (fifo_pop),
        .fifo_data   (fifo_data),
        .fifo_read_en(fifo_read_en),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_data      (m_data),
        .busy        (busy),
        .in_flight   (in_flight),
        .err_unexp   (err_unexp)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // FIFO model: storage plus a LAT-deep return pipeline, independent of DUT reset.
    logic [DW-1:0] fmem [256];
    int            head;
    int            tail;
    logic          flush;
    logic          pipe_v [LAT];
    logic [DW-1:0] pipe_d [LAT];
    logic          inj;
    logic [DW-1:0] inj_d;

    assign fifo_empty   = (head == tail);
    assign fifo_read_en = pipe_v[LAT-1] | inj;
    assign fifo_data    = inj ? inj_d : pipe_d[LAT-1];

    always @(posedge clock) begin
        if (flush) begin
            head <= tail;
            for (int i = 0; i < LAT; i++) begin
                pipe_v[i] <= 1'b0;
                pipe_d[i] <= '0;
            end
        end else begin
            if (fifo_pop) head <= head + 1;
            pipe_v[0] <= fifo_pop;
            pipe_d[0] <= fmem[head[7:0]];
            for (int i = 1; i < LAT; i++) begin
                pipe_v[i] <= pipe_v[i-1];
                pipe_d[i] <= pipe_d[i-1];
            end
        end
    end

    // Stream collector and event statistics.
    logic          clr;
    int            cyc;
    int            pop_cnt;
    int            first_pop;
    int            last_pop;
    int            first_v;
    int            last_v;
    int            vcnt;
    int            max_if;
    logic [DW-1:0] rx [$];

    always @(posedge clock) begin
        cyc <= cyc + 1;
        if (clr) begin
            pop_cnt   <= 0;
            first_pop <= -1;
            last_pop  <= -1;
            first_v   <= -1;
            last_v    <= -1;
            vcnt      <= 0;
            max_if    <= 0;
            rx.delete();
        end else begin
            if (fifo_pop) begin
                pop_cnt <= pop_cnt + 1;
                if (first_pop < 0) first_pop <= cyc;
                last_pop <= cyc;
            end
            if (m_valid) begin
                if (first_v < 0) first_v <= cyc;
                last_v <= cyc;
                vcnt   <= vcnt + 1;
            end
            if (m_valid && m_ready) rx.push_back(m_data);
            if (int'(in_flight) > max_if) max_if <= int'(in_flight);
        end
    end

    int n_checks;
    int n_fail;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int rx_errs(input int base, input int n);
        int e = 0;
        for (int i = 0; i < n; i++) begin
            if (i >= rx.size()) e++;
            else if (rx[i] != 8'(base + i)) e++;
        end
        return e;
    endfunction

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic push(input int d);
        fmem[tail[7:0]] = 8'(d);
        tail = tail + 1;
    endtask

    task automatic do_reset(input bit fl);
        reset   = 1'b0;
        enable  = 1'b0;
        m_ready = 1'b0;
        inj     = 1'b0;
        flush   = fl;
        clr     = 1'b1;
        wait_neg(6);
        reset = 1'b1;
        flush = 1'b0;
        clr   = 1'b0;
    endtask

    int t0;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        tail     = 0;
        inj_d    = '0;
        do_reset(1'b1);

        // Reset state
        check("rst_valid", int'(m_valid), 0);
        check("rst_pop", int'(fifo_pop), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_inflight", int'(in_flight), 0);
        check("rst_err", int'(err_unexp), 0);
        check("rst_data", int'(m_data), 0);

        // Sustained stream of 0x11..0x1A
        for (int i = 0; i < 10; i++) push(8'h11 + i);
        wait_neg(1);
        t0      = cyc;
        enable  = 1'b1;
        m_ready = 1'b1;
        wait_neg(25);
        check("str_pops", pop_cnt, 10);
        check("str_first_pop", first_pop - t0, 1);
        check("str_last_pop", last_pop - t0, 10);
        check("str_first_valid", first_v - t0, 6);
        check("str_valid_cycles", vcnt, 10);
        check("str_no_gap", last_v - first_v, 9);
        check("str_rx_cnt", rx.size(), 10);
        check("str_rx_order", rx_errs(8'h11, 10), 0);

        // Backpressure: credits cap pops at the buffer depth
        do_reset(1'b1);
        for (int i = 0; i < 20; i++) push(8'h40 + i);
        enable  = 1'b1;
        m_ready = 1'b0;
        wait_neg(20);
        check("bp_pops", pop_cnt, 8);
        check("bp_max_inflight", max_if, 4);
        check("bp_valid", int'(m_valid), 1);
        check("bp_head", int'(m_data), 8'h40);
        check("bp_inflight", int'(in_flight), 0);
        check("bp_pop_held", int'(fifo_pop), 0);
        m_ready = 1'b1;
        wait_neg(40);
        check("bp_pops_total", pop_cnt, 20);
        check("bp_rx_cnt", rx.size(), 20);
        check("bp_rx_order", rx_errs(8'h40, 20), 0);

        // Stop with three pops outstanding
        do_reset(1'b1);
        for (int i = 0; i < 20; i++) push(8'h60 + i);
        enable  = 1'b1;
        m_ready = 1'b1;
        wait_neg(3);
        enable = 1'b0;
        wait_neg(1);
        check("stop_inflight", int'(in_flight), 3);
        check("stop_pop", int'(fifo_pop), 0);
        check("stop_busy_hi", int'(busy), 1);
        for (int i = 0; i < 20 && in_flight != 0; i++) @(negedge clock);
        check("stop_drained", int'(in_flight), 0);
        check("stop_busy_lo", int'(busy), 0);
        wait_neg(5);
        check("stop_pops", pop_cnt, 3);
        check("stop_rx_cnt", rx.size(), 3);
        check("stop_rx_order", rx_errs(8'h60, 3), 0);

        // FIFO runs empty, then refills
        do_reset(1'b1);
        push(8'h70);
        push(8'h71);
        enable  = 1'b1;
        m_ready = 1'b1;
        wait_neg(7);
        check("empty_pops", pop_cnt, 2);
        check("empty_pop_lo", int'(fifo_pop), 0);
        check("empty_busy", int'(busy), 1);
        for (int i = 0; i < 3; i++) push(8'h72 + i);
        wait_neg(20);
        check("refill_pops", pop_cnt, 5);
        check("refill_rx_cnt", rx.size(), 5);
        check("refill_rx_order", rx_errs(8'h70, 5), 0);

        // Asynchronous reset mid-transfer; late returns are flagged
        do_reset(1'b1);
        for (int i = 0; i < 10; i++) push(8'h80 + i);
        enable  = 1'b1;
        m_ready = 1'b1;
        wait_neg(7);
        check("mid_inflight", int'(in_flight), 4);
        check("mid_valid", int'(m_valid), 1);
        #2 reset = 1'b0;
        enable = 1'b0;
        #1;
        check("arst_valid", int'(m_valid), 0);
        check("arst_pop", int'(fifo_pop), 0);
        check("arst_busy", int'(busy), 0);
        check("arst_inflight", int'(in_flight), 0);
        check("arst_data", int'(m_data), 0);
        wait_neg(1);
        reset = 1'b1;
        check("rel_valid", int'(m_valid), 0);
        check("rel_inflight", int'(in_flight), 0);
        wait_neg(4);
        check("late_err", int'(err_unexp), 1);
        check("late_valid", int'(m_valid), 0);

        // Spurious return with nothing in flight
        do_reset(1'b1);
        check("spur_err_clr", int'(err_unexp), 0);
        inj   = 1'b1;
        inj_d = 8'hAA;
        wait_neg(1);
        inj = 1'b0;
        check("spur_err", int'(err_unexp), 1);
        check("spur_valid", int'(m_valid), 0);
        wait_neg(4);
        check("spur_sticky", int'(err_unexp), 1);
        check("spur_rx_cnt", rx.size(), 0);
        check("spur_inflight", int'(in_flight), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
